// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage pipelined barrel shifter with valid/ready handshake on both sides.
// Modes: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal (data passes unmodified).
// Stage 1 applies the upper shamt bits [SHW-1:SPLIT]; stage 2 applies the low bits and the flags.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready             input handshake
//   in_data, in_shamt, in_mode    operand, shift amount, operation
//   in_tag                        sideband, passed through unchanged
//   out_valid/out_ready           output handshake
//   out_data, out_tag             result and its tag
//   out_zero                      out_data == 0
//   out_lost                      a 1 bit was shifted out (SLL/SRL/SRA only)
//   out_illegal                   mode was 101-111
module shift_unit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 6,
    localparam int unsigned SHW   = $clog2(WIDTH),
    localparam int unsigned SPLIT = SHW / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_lost,
    output logic             out_illegal
);

    localparam logic [2:0] ModeSll = 3'b000;
    localparam logic [2:0] ModeSrl = 3'b001;
    localparam logic [2:0] ModeSra = 3'b010;
    localparam logic [2:0] ModeRol = 3'b011;
    localparam logic [2:0] ModeRor = 3'b100;

    // One log stage of amount amt (1..WIDTH/2). Returns {lost, data}.
    // Bits shifted in at the top can never reach the bottom within a total shift below WIDTH,
    // so OR-ing the per-stage discarded bits yields exactly the original bits lost.
    function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       mode,
                                                  input int unsigned      amt);
        logic signed [WIDTH-1:0] ds;
        logic [WIDTH-1:0]        r;
        logic                    lost;
        ds   = d;
        r    = d;
        lost = 1'b0;
        case (mode)
            ModeSll: begin
                r    = d << amt;
                lost = |(d >> (WIDTH - amt));
            end
            ModeSrl: begin
                r    = d >> amt;
                lost = |(d << (WIDTH - amt));
            end
            ModeSra: begin
                // MSB of a partial SRA result always equals the original MSB.
                r    = ds >>> amt;
                lost = |(d << (WIDTH - amt));
            end
            ModeRol: r = (d << amt) | (d >> (WIDTH - amt));
            ModeRor: r = (d >> amt) | (d << (WIDTH - amt));
            default: ;
        endcase
        return {lost, r};
    endfunction

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [SPLIT-1:0] s1_lo_q;
    logic [2:0]       s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_lost_q,  s1_lost_d;
    logic             s1_illegal_q, s1_illegal_d;

    // Stage 2 registers
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic [TAG_W-1:0] s2_tag_q;
    logic             s2_zero_q,  s2_zero_d;
    logic             s2_lost_q,  s2_lost_d;
    logic             s2_illegal_q;

    logic s1_en, s2_en;
    logic [WIDTH:0] step1, step2;

    assign s2_en    = !s2_valid_q | out_ready;
    assign s1_en    = !s1_valid_q | s2_en;
    assign in_ready = s1_en & !reset;

    always_comb begin
        step1        = '0;
        s1_data_d    = in_data;
        s1_lost_d    = 1'b0;
        s1_illegal_d = (in_mode > ModeRor);
        for (int k = SPLIT; k < SHW; k++) begin
            if (in_shamt[k]) begin
                step1     = shift_step(s1_data_d, in_mode, 1 << k);
                s1_data_d = step1[WIDTH-1:0];
                s1_lost_d = s1_lost_d | step1[WIDTH];
            end
        end
    end

    always_comb begin
        step2     = '0;
        s2_data_d = s1_data_q;
        s2_lost_d = s1_lost_q;
        for (int k = 0; k < SPLIT; k++) begin
            if (s1_lo_q[k]) begin
                step2     = shift_step(s2_data_d, s1_mode_q, 1 << k);
                s2_data_d = step2[WIDTH-1:0];
                s2_lost_d = s2_lost_d | step2[WIDTH];
            end
        end
        s2_zero_d = (s2_data_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_lo_q      <= '0;
            s1_mode_q    <= '0;
            s1_tag_q     <= '0;
            s1_lost_q    <= 1'b0;
            s1_illegal_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_tag_q     <= '0;
            s2_zero_q    <= 1'b0;
            s2_lost_q    <= 1'b0;
            s2_illegal_q <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q    <= s1_data_d;
                    s1_lo_q      <= in_shamt[SPLIT-1:0];
                    s1_mode_q    <= in_mode;
                    s1_tag_q     <= in_tag;
                    s1_lost_q    <= s1_lost_d;
                    s1_illegal_q <= s1_illegal_d;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q    <= s2_data_d;
                    s2_tag_q     <= s1_tag_q;
                    s2_zero_q    <= s2_zero_d;
                    s2_lost_q    <= s2_lost_d;
                    s2_illegal_q <= s1_illegal_q;
                end
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = s2_data_q;
    assign out_tag     = s2_tag_q;
    assign out_zero    = s2_zero_q;
    assign out_lost    = s2_lost_q;
    assign out_illegal = s2_illegal_q;

endmodule
